// File: rtl/dmem_pkg.sv
// Shared definitions for the sized, wait-stated data memory.
// Size encodings, FSM state encoding and the byte-lane mask helper.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WAIT  = 2'b01,
    RESP  = 2'b10,
    CLEAR = 2'b11
  } state_t;

  // Byte lanes of a 32-bit word touched by an access of the given size
  // starting at the given low address bits. Reserved size touches nothing.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] mask;
    mask = 4'b0000;
    case (size)
      SZ_BYTE: mask = 4'b0001 << addr_lo;
      SZ_HALF: mask = 4'b0011 << addr_lo;
      SZ_WORD: mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Read-path alignment: moves the addressed lanes of a fetched word down to
// bit 0 and applies sign or zero extension for byte and half reads.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted_s;

  // Right-align the selected lanes, then extend according to size and signedness
  always_comb begin
    shifted_s = word_i >> {off_i, 3'b000};
    data_o    = 32'h0000_0000;
    case (size_i)
      SZ_BYTE: begin
        if (unsigned_i) begin
          data_o = {24'h00_0000, shifted_s[7:0]};
        end else begin
          data_o = {{24{shifted_s[7]}}, shifted_s[7:0]};
        end
      end
      SZ_HALF: begin
        if (unsigned_i) begin
          data_o = {16'h0000, shifted_s[15:0]};
        end else begin
          data_o = {{16{shifted_s[15]}}, shifted_s[15:0]};
        end
      end
      SZ_WORD: data_o = word_i;
      default: data_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/dmem_sized_ws.sv
// Byte-addressed little-endian data memory with byte/half/word accesses,
// alignment/range checking and a req/ready handshake with WAIT_CYCLES wait
// states. Optional build macro DMEM_RESET_CLEAR_EN adds a post-reset CLEAR
// state that zeroes the array one byte per cycle before accepting requests.
module dmem_sized_ws
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_BYTES = 128,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic              done_o,
  output logic              err_o,
  output logic [DATA_W-1:0] data_o
);

  localparam int IDX_W = $clog2(DEPTH_BYTES);
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH_BYTES);
  localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [IDX_W-1:0]  LANE_CLR  = ~IDX_W'(3);

  state_t            state_r;
  logic [CNT_W-1:0]  wcnt_r;
  logic [IDX_W-1:0]  addr_r;
  logic [31:0]       wdata_r;
  logic [1:0]        size_r;
  logic              we_r;
  logic              uns_r;
  logic              perr_r;
  logic              ready_r;
  logic              done_r;
  logic              err_r;
  logic [31:0]       rdata_r;
`ifdef DMEM_RESET_CLEAR_EN
  logic [IDX_W-1:0]  clr_cnt_r;
`endif

  logic [7:0]        mem_r [DEPTH_BYTES];

  logic              accept_s;
  logic              misalign_s;
  logic              err_s;
  logic [IDX_W-1:0]  base_s;
  logic [3:0]        wmask_s;
  logic [31:0]       wshift_s;
  logic [31:0]       rword_s;
  logic [31:0]       rdata_s;

  assign accept_s = req_i & ready_r & (state_r == IDLE);

  // Classify the incoming request: misalignment, reserved size, or out of range
  always_comb begin
    misalign_s = 1'b0;
    case (size_i)
      SZ_BYTE: misalign_s = 1'b0;
      SZ_HALF: misalign_s = addr_i[0];
      SZ_WORD: misalign_s = (addr_i[1:0] != 2'b00);
      default: misalign_s = 1'b1;
    endcase
    err_s = misalign_s | (addr_i >= DEPTH_A);
  end

  // Word-aligned array index plus write lane enables and lane-shifted write data
  always_comb begin
    base_s   = addr_r & LANE_CLR;
    wshift_s = wdata_r << {addr_r[1:0], 3'b000};
    if ((state_r == RESP) && we_r && !perr_r) begin
      wmask_s = lane_mask(size_r, addr_r[1:0]);
    end else begin
      wmask_s = 4'b0000;
    end
    rword_s = {mem_r[base_s | IDX_W'(3)], mem_r[base_s | IDX_W'(2)],
               mem_r[base_s | IDX_W'(1)], mem_r[base_s]};
  end

  dmem_lane_align u_align (
    .word_i     (rword_s),
    .off_i      (addr_r[1:0]),
    .size_i     (size_r),
    .unsigned_i (uns_r),
    .data_o     (rdata_s)
  );

  // Byte array: lane writes at the RESP edge, zero-fill while clearing; never reset
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask_s[i]) begin
          mem_r[base_s | IDX_W'(i)] <= wshift_s[8*i +: 8];
        end
      end
`ifdef DMEM_RESET_CLEAR_EN
      if (state_r == CLEAR) begin
        mem_r[clr_cnt_r] <= 8'h00;
      end
`endif
    end
  end

  // Access FSM: accept, count wait states, respond with a one-cycle done pulse
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
`ifdef DMEM_RESET_CLEAR_EN
      state_r   <= CLEAR;
      ready_r   <= 1'b0;
      clr_cnt_r <= '0;
`else
      state_r   <= IDLE;
      ready_r   <= 1'b1;
`endif
      wcnt_r    <= '0;
      addr_r    <= '0;
      wdata_r   <= 32'h0000_0000;
      size_r    <= SZ_BYTE;
      we_r      <= 1'b0;
      uns_r     <= 1'b0;
      perr_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      rdata_r   <= 32'h0000_0000;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            addr_r  <= addr_i[IDX_W-1:0];
            wdata_r <= data_i[31:0];
            size_r  <= size_i;
            we_r    <= we_i;
            uns_r   <= unsigned_i;
            perr_r  <= err_s;
            wcnt_r  <= '0;
            ready_r <= 1'b0;
            state_r <= (WAIT_CYCLES > 0) ? WAIT : RESP;
          end else begin
            ready_r <= 1'b1;
          end
        end
        WAIT: begin
          if (wcnt_r == WAIT_LAST) begin
            state_r <= RESP;
          end else begin
            wcnt_r <= wcnt_r + CNT_W'(1);
          end
        end
        RESP: begin
          done_r  <= 1'b1;
          err_r   <= perr_r;
          if (perr_r) begin
            rdata_r <= 32'h0000_0000;
          end else if (!we_r) begin
            rdata_r <= rdata_s;
          end
          ready_r <= 1'b1;
          state_r <= IDLE;
        end
        CLEAR: begin
`ifdef DMEM_RESET_CLEAR_EN
          clr_cnt_r <= clr_cnt_r + IDX_W'(1);
          if (clr_cnt_r == IDX_W'(DEPTH_BYTES - 1)) begin
            ready_r <= 1'b1;
            state_r <= IDLE;
          end
`else
          ready_r <= 1'b1;
          state_r <= IDLE;
`endif
        end
        default: begin
          ready_r <= 1'b1;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign ready_o = ready_r;
  assign done_o  = done_r;
  assign err_o   = err_r;
  assign data_o  = DATA_W'(rdata_r);

endmodule

// File: tb/tb_dmem_sized_ws.sv
// Directed self-checking bench for dmem_sized_ws (WAIT_CYCLES=2, DEPTH_BYTES=128).
module tb_dmem_sized_ws;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  sz = 2'b00;
  logic        uns = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        ready;
  logic        done;
  logic        err;
  logic [31:0] rdata;

  int total = 0;
  int bad = 0;

  dmem_sized_ws #(
    .DATA_W(32), .ADDR_W(32), .DEPTH_BYTES(128), .WAIT_CYCLES(2)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .size_i(sz),
    .unsigned_i(uns), .addr_i(addr), .data_i(wdata),
    .ready_o(ready), .done_o(done), .err_o(err), .data_o(rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One access: request driven at negedge, accepted at the next posedge;
  // lat counts posedges after acceptance until done_o is seen.
  task automatic access(input logic w, input logic [1:0] s, input logic u,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    req = 1'b1; we = w; sz = s; uns = u; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = rdata;
    er = err;
  endtask

  task automatic wait_ready(input string tag, output int cycles);
    cycles = 0;
    while (ready !== 1'b1 && cycles < 400) begin
      @(posedge clk); #1;
      cycles++;
    end
    check(tag, {31'h0, ready}, 32'h1);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          cyc;
  int          ndone;
  logic [31:0] held;

  initial begin
    // Reset with a request asserted: must be ignored
    rst = 1'b1; req = 1'b1; we = 1'b0; sz = 2'b10; addr = 32'h10;
    repeat (2) @(posedge clk);
    #1;
`ifdef DMEM_RESET_CLEAR_EN
    check("rst_ready", {31'h0, ready}, 32'h0);
`else
    check("rst_ready", {31'h0, ready}, 32'h1);
`endif
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    check("rst_data", rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0; req = 1'b0;
`ifdef DMEM_RESET_CLEAR_EN
    @(posedge clk); #1;
    cyc = 1;
    while (ready !== 1'b1 && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("clear_len", cyc, 32'd128);
    access(1'b0, 2'b10, 1'b0, 32'h7C, 32'h0, rd, er, lat);
    check("clear_rd7c", rd, 32'h0);
`else
    @(posedge clk); #1;
    check("ready_after_rst", {31'h0, ready}, 32'h1);
`endif
    ndone = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done === 1'b1) ndone++;
    end
    check("req_in_rst_ignored", ndone, 32'd0);

    // Word write then word read, latency and error flag
    access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat);
    check("wr_lat", lat, 32'd3);
    check("wr_err", {31'h0, er}, 32'h0);
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
    check("rd_lat", lat, 32'd3);
    check("rd_word", rd, 32'hDEADBEEF);
    check("rd_err", {31'h0, er}, 32'h0);
    check("ready_at_done", {31'h0, ready}, 32'h1);
    @(posedge clk); #1;
    check("done_pulse", {31'h0, done}, 32'h0);

    // Byte reads with sign and zero extension
    access(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, rd, er, lat);
    check("rd_b13_s", rd, 32'hFFFFFFDE);
    access(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, rd, er, lat);
    check("rd_b13_u", rd, 32'h000000DE);
    access(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, rd, er, lat);
    check("rd_b11_s", rd, 32'hFFFFFFBE);

    // Half write into upper half, neighbours untouched
    access(1'b1, 2'b01, 1'b0, 32'h12, 32'h00001234, rd, er, lat);
    check("wr_h12_err", {31'h0, er}, 32'h0);
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
    check("rd_w10_after_h", rd, 32'h1234BEEF);
    access(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, rd, er, lat);
    check("rd_h10_u", rd, 32'h0000BEEF);
    access(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, rd, er, lat);
    check("rd_h10_s", rd, 32'hFFFFBEEF);
    held = rd;
    repeat (3) @(posedge clk);
    #1;
    check("data_hold", rdata, held);

    // Error cases: writes that must not commit
    access(1'b1, 2'b10, 1'b0, 32'h00, 32'h11223344, rd, er, lat);
    access(1'b1, 2'b00, 1'b0, 32'h7F, 32'h0000005A, rd, er, lat);
    access(1'b1, 2'b10, 1'b0, 32'h02, 32'hFFFFFFFF, rd, er, lat);
    check("e_w02_err", {31'h0, er}, 32'h1);
    check("e_w02_data", rd, 32'h0);
    check("e_w02_lat", lat, 32'd3);
    access(1'b1, 2'b01, 1'b0, 32'h7F, 32'h0000A5A5, rd, er, lat);
    check("e_h7f_err", {31'h0, er}, 32'h1);
    check("e_h7f_data", rd, 32'h0);
    access(1'b1, 2'b10, 1'b0, 32'h80, 32'hCAFEF00D, rd, er, lat);
    check("e_w80_err", {31'h0, er}, 32'h1);
    check("e_w80_data", rd, 32'h0);
    access(1'b1, 2'b11, 1'b0, 32'h00, 32'h99999999, rd, er, lat);
    check("e_sz11_err", {31'h0, er}, 32'h1);
    check("e_sz11_data", rd, 32'h0);
    access(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, rd, er, lat);
    check("e_sz11_rd_err", {31'h0, er}, 32'h1);
    check("e_sz11_rd_data", rd, 32'h0);
    access(1'b0, 2'b10, 1'b0, 32'h00, 32'h0, rd, er, lat);
    check("unchanged_w00", rd, 32'h11223344);
    check("unchanged_w00_err", {31'h0, er}, 32'h0);
    access(1'b0, 2'b00, 1'b1, 32'h7F, 32'h0, rd, er, lat);
    check("unchanged_b7f", rd, 32'h0000005A);

    // req held high through WAIT must not start another access
    @(negedge clk);
    req = 1'b1; we = 1'b0; sz = 2'b10; uns = 1'b0; addr = 32'h10;
    @(posedge clk); #1;
    check("busy_ready0", {31'h0, ready}, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("busy_ready0_late", {31'h0, ready}, 32'h0);
    req = 1'b0;
    ndone = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done === 1'b1) ndone++;
    end
    check("busy_one_done", ndone, 32'd1);

    // Reset during WAIT of a write aborts it
    access(1'b1, 2'b00, 1'b0, 32'h20, 32'h00000055, rd, er, lat);
    @(negedge clk);
    req = 1'b1; we = 1'b1; sz = 2'b00; addr = 32'h20; wdata = 32'h000000AA;
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ndone = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done === 1'b1) ndone++;
    end
    check("abort_no_done", ndone, 32'd0);
    wait_ready("abort_ready", cyc);
    access(1'b0, 2'b00, 1'b1, 32'h20, 32'h0, rd, er, lat);
`ifdef DMEM_RESET_CLEAR_EN
    check("abort_old_value", rd, 32'h00000000);
`else
    check("abort_old_value", rd, 32'h00000055);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
